led_binary_counter: RTL and testbench

- Free-running binary counter that drives the eight onboard LEDs of the Mojo top level at a human-visible rate.
- Divides the 50 MHz board clock down to a count tick and advances an up/down counter on each tick.
- Takes a raw push-button input that toggles count direction, after synchronisation and debouncing.
- Sits directly upstream of the top-level led[7:0] output.

---
 rtl/mojo_pkg.sv | 21 ++
 rtl/button_debouncer.sv | 91 +++++++++
 rtl/led_binary_counter.sv | 98 +++++++++
 tb/tb_led_binary_counter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mojo_pkg.sv
// ============================================================================
// mojo_pkg: shared constants and debouncer state encoding for the Mojo top level
// Revision: 1.0
// ============================================================================
`default_nettype none

package mojo_pkg;

  localparam int LED_WIDTH = 8;
  localparam int CLK_HZ    = 50_000_000;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } deb_state_e;

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// button_debouncer: two-flop synchroniser plus hold-time debouncer FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_debouncer
  import mojo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int HW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(DEBOUNCE_CYCLES - 1);

  logic          sync0_q, sync0_d;
  logic          sync1_q, sync1_d;
  deb_state_e    state_q, state_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic          press_q, press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      state_q <= S_LOW;
      hold_q  <= '0;
      press_q <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    sync0_d = btn_raw;
    sync1_d = sync0_q;
    state_d = state_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync1_q) begin
          state_d = S_RISE;
          hold_d  = '0;
        end
      end
      S_RISE: begin
        if (!sync1_q) begin
          state_d = S_LOW;
        end else if (hold_q == HOLD_MAX) begin
          state_d = S_HIGH;
          press_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!sync1_q) begin
          state_d = S_FALL;
          hold_d  = '0;
        end
      end
      S_FALL: begin
        if (sync1_q) begin
          state_d = S_HIGH;
        end else if (hold_q == HOLD_MAX) begin
          state_d = S_LOW;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  assign level = (state_q == S_HIGH) || (state_q == S_FALL);
  assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/led_binary_counter.sv
// ============================================================================
// led_binary_counter: prescaled up/down LED counter, button toggles direction
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_binary_counter
  import mojo_pkg::*;
#(
  parameter int WIDTH           = LED_WIDTH,
  parameter int TICK_DIV        = 12500000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             dir_btn,
  output logic [WIDTH-1:0] led,
  output logic             dir_up,
  output logic             tick,
  output logic             wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] LED_MAX   = '1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] led_q,   led_d;
  logic             dir_q,   dir_d;
  logic             tick_q,  tick_d;
  logic             wrap_q,  wrap_d;
  logic             btn_level;
  logic             btn_press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(dir_btn),
    .level  (btn_level),
    .press  (btn_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      led_q   <= '0;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    presc_d = presc_q;
    led_d   = led_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    // A press only counts while the debounced level is high; the step below
    // still uses dir_q, so a coincident press affects only the next step.
    dir_d   = dir_q ^ (btn_press & btn_level);
    if (clear) begin
      presc_d = '0;
      led_d   = '0;
    end else if (en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (dir_q) begin
          led_d  = led_q + 1'b1;
          wrap_d = (led_q == LED_MAX);
        end else begin
          led_d  = led_q - 1'b1;
          wrap_d = (led_q == '0);
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign led    = led_q;
  assign dir_up = dir_q;
  assign tick   = tick_q;
  assign wrap   = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_led_binary_counter.sv
// ============================================================================
// tb_led_binary_counter: scoreboard bench for led_binary_counter (TICK_DIV=4, DEBOUNCE_CYCLES=8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_binary_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic       dir_btn;
  logic [7:0] led;
  logic       dir_up;
  logic       tick;
  logic       wrap;

  int n_tests = 0;
  int n_fail  = 0;

  // Each entry is {wrap, led} expected on the next tick.
  logic [8:0] exp_q[$];

  led_binary_counter #(
    .WIDTH          (8),
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clear  (clear),
    .dir_btn(dir_btn),
    .led    (led),
    .dir_up (dir_up),
    .tick   (tick),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [7:0] start, input int n, input logic up);
    logic [7:0] cur;
    logic [7:0] nxt;
    logic       w;
    cur = start;
    for (int i = 0; i < n; i++) begin
      nxt = up ? cur + 8'd1 : cur - 8'd1;
      w   = up ? (cur == 8'hFF) : (cur == 8'h00);
      exp_q.push_back({w, nxt});
      cur = nxt;
    end
  endtask

  task automatic run_cycles(input string name, input int n, input int period, input int phase);
    logic [8:0] e;
    logic       exp_tick;
    for (int k = 0; k < n; k++) begin
      step_clk();
      exp_tick = ((k % period) == phase);
      n_tests++;
      if (tick !== exp_tick) begin
        n_fail++;
        $display("FAIL %s tick cycle %0d: got %b expected %b", name, k, tick, exp_tick);
      end
      if (tick === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected tick cycle %0d: led %h wrap %b, nothing expected", name, k, led, wrap);
        end else begin
          e = exp_q.pop_front();
          if ({wrap, led} !== e) begin
            n_fail++;
            $display("FAIL %s step value: got led %h wrap %b expected led %h wrap %b",
                     name, led, wrap, e[7:0], e[8]);
          end
        end
      end else begin
        n_tests++;
        if (wrap !== 1'b0) begin
          n_fail++;
          $display("FAIL %s wrap without tick cycle %0d: got %b expected 0", name, k, wrap);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing ticks: %0d expected steps never seen, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Holds the button for 20 cycles (toggle expected 11 edges after the first
  // sampling edge), then releases for 20 cycles with no further toggle.
  task automatic do_press(input string name, input logic old_dir);
    logic exp_dir;
    dir_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step_clk();
      exp_dir = (k >= 11) ? ~old_dir : old_dir;
      n_tests++;
      if (dir_up !== exp_dir) begin
        n_fail++;
        $display("FAIL %s hold cycle %0d dir_up: got %b expected %b", name, k, dir_up, exp_dir);
      end
    end
    dir_btn = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step_clk();
      n_tests++;
      if (dir_up !== ~old_dir) begin
        n_fail++;
        $display("FAIL %s release cycle %0d dir_up: got %b expected %b", name, k, dir_up, ~old_dir);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; dir_btn = 1'b0;
    repeat (3) step_clk();
    check_val("reset led", led, 8'h00);
    check_val("reset dir_up", {7'd0, dir_up}, 8'h01);
    check_val("reset tick", {7'd0, tick}, 8'h00);
    check_val("reset wrap", {7'd0, wrap}, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    en = 1'b1;
    push_run(8'h00, 10, 1'b1);
    run_cycles("count", 40, 4, 3);
    check_drained("count");
    check_val("count dir_up", {7'd0, dir_up}, 8'h01);
  endtask

  task automatic test_wrap_up();
    push_run(8'h0A, 246, 1'b1);
    run_cycles("wrap_up", 984, 4, 3);
    check_drained("wrap_up");
    check_val("wrap_up final led", led, 8'h00);
  endtask

  task automatic test_button();
    en = 1'b0;
    dir_btn = 1'b1;
    repeat (5) step_clk();
    dir_btn = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step_clk();
      n_tests++;
      if (dir_up !== 1'b1) begin
        n_fail++;
        $display("FAIL glitch cycle %0d dir_up: got %b expected 1", k, dir_up);
      end
    end
    do_press("press1", 1'b1);
    check_val("button frozen led", led, 8'h00);
  endtask

  task automatic test_wrap_down();
    en = 1'b1;
    push_run(8'h00, 1, 1'b0);
    run_cycles("wrap_down", 4, 4, 3);
    check_drained("wrap_down");
    en = 1'b0;
    do_press("press2", 1'b0);
    en = 1'b1;
    push_run(8'hFF, 1, 1'b1);
    run_cycles("wrap_up_again", 4, 4, 3);
    check_drained("wrap_up_again");
  endtask

  task automatic test_clear();
    push_run(8'h00, 5, 1'b1);
    run_cycles("pre_clear", 20, 4, 3);
    check_drained("pre_clear");
    run_cycles("pre_clear_presc", 3, 4, 3);
    check_val("pre_clear led", led, 8'h05);
    clear = 1'b1;
    step_clk();
    clear = 1'b0;
    check_val("clear led", led, 8'h00);
    check_val("clear tick", {7'd0, tick}, 8'h00);
    check_val("clear wrap", {7'd0, wrap}, 8'h00);
    push_run(8'h00, 1, 1'b1);
    run_cycles("post_clear", 4, 4, 3);
    check_drained("post_clear");
  endtask

  task automatic test_enable();
    push_run(8'h01, 6, 1'b1);
    run_cycles("pre_enable", 24, 4, 3);
    check_drained("pre_enable");
    run_cycles("pre_enable_presc", 2, 4, 3);
    check_val("pre_enable led", led, 8'h07);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step_clk();
      n_tests++;
      if (led !== 8'h07 || tick !== 1'b0) begin
        n_fail++;
        $display("FAIL frozen cycle %0d: got led %h tick %b expected led 07 tick 0", k, led, tick);
      end
    end
    en = 1'b1;
    push_run(8'h07, 1, 1'b1);
    run_cycles("resume", 2, 4, 1);
    check_drained("resume");
  endtask

  task automatic test_reset_mid();
    logic exp_dir;
    push_run(8'h08, 43, 1'b1);
    run_cycles("to_33", 172, 4, 3);
    check_drained("to_33");
    en = 1'b0;
    do_press("press3", 1'b1);
    check_val("pre_reset led", led, 8'h33);
    check_val("pre_reset dir_up", {7'd0, dir_up}, 8'h00);
    dir_btn = 1'b1;
    repeat (7) step_clk();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async reset led", led, 8'h00);
    check_val("async reset dir_up", {7'd0, dir_up}, 8'h01);
    check_val("async reset tick", {7'd0, tick}, 8'h00);
    check_val("async reset wrap", {7'd0, wrap}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step_clk();
      exp_dir = (k >= 11) ? 1'b0 : 1'b1;
      n_tests++;
      if (dir_up !== exp_dir) begin
        n_fail++;
        $display("FAIL post_reset debounce cycle %0d dir_up: got %b expected %b", k, dir_up, exp_dir);
      end
    end
    dir_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap_up();
    test_button();
    test_wrap_down();
    test_clear();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
